// File: rtl/x_cmd_des_pkg.sv
// Shared opcodes, FSM state type and nibble width for the command deserialiser.
// Imported by the bank shift register and the top-level decoder/sequencer.
package x_cmd_des_pkg;

    localparam int NIBBLE_W = 4;

    // Any op with op[3] at this value is a SHIFT into bank op[2:0].
    localparam logic       OP_SHIFT_MSB = 1'b0;
    localparam logic [3:0] OP_APPLY     = 4'h8;
    localparam logic [3:0] OP_CLEAR     = 4'h9;

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

endpackage

// File: rtl/x_cmd_des_bank.sv
// One shadow bank: a WIDTH-bit register that shifts in a nibble at the LSB end.
// Nibbles pushed past the top fall off the MSB end without notice.
module x_cmd_des_bank
    import x_cmd_des_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                shift_en,
    input  logic                clear,
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [WIDTH-1:0]    data
);

    // A single-nibble bank has no lower bits to keep, so it simply reloads.
    if (WIDTH == NIBBLE_W) begin : g_single
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data <= '0;
            end else if (clear) begin
                data <= '0;
            end else if (shift_en) begin
                data <= nibble;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data <= '0;
            end else if (clear) begin
                data <= '0;
            end else if (shift_en) begin
                data <= {data[WIDTH-NIBBLE_W-1:0], nibble};
            end
        end
    end

endmodule

// File: rtl/x_cmd_des.sv
// Nibble command deserialiser: SHIFT/CLEAR edit the shadow banks and APPLY
// streams every bank onto o_data, one bank per cycle, with index and strobe.
module x_cmd_des
    import x_cmd_des_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int NUM_BANKS = 2,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_accept,
    input  logic [7:0]        i_cmd,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_valid,
    output logic [BANK_W-1:0] o_bank
);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W || NUM_BANKS < 1 || NUM_BANKS > 8) begin : g_bad_param
        $fatal(1, "x_cmd_des: WIDTH must be a multiple of 4 (>=4) and NUM_BANKS in 1..8");
    end

    state_t            state;
    state_t            next_state;
    logic [BANK_W-1:0] cnt;
    logic [BANK_W-1:0] next_cnt;
    logic              load;
    logic [BANK_W-1:0] load_idx;
    logic [WIDTH-1:0]  bank_q [NUM_BANKS];

    logic       take;
    logic [3:0] op;
    logic       clear_all;
    logic       start_apply;

    assign o_accept    = (state == IDLE);
    assign take        = i_valid & o_accept;
    assign op          = i_cmd[7:4];
    assign clear_all   = take && (op == OP_CLEAR);
    assign start_apply = take && (op == OP_APPLY);

    // Out-of-range bank selects match no instance and therefore do nothing.
    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        x_cmd_des_bank #(
            .WIDTH (WIDTH)
        ) u_bank (
            .clk      (i_clk),
            .rst      (i_rst),
            .shift_en (take && (op[3] == OP_SHIFT_MSB) && (op[2:0] == 3'(i))),
            .clear    (clear_all),
            .nibble   (i_cmd[3:0]),
            .data     (bank_q[i])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Bank 0 goes out on the accepting edge itself; APPLY covers banks 1..N-1.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        load       = 1'b0;
        load_idx   = '0;
        case (state)
            IDLE: begin
                if (start_apply) begin
                    load = 1'b1;
                    if (NUM_BANKS > 1) begin
                        next_state = APPLY;
                        next_cnt   = BANK_W'(1);
                    end
                end
            end
            APPLY: begin
                load     = 1'b1;
                load_idx = cnt;
                if (cnt == BANK_W'(NUM_BANKS - 1)) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + BANK_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data  <= '0;
            o_bank  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= load;
            if (load) begin
                o_data <= bank_q[load_idx];
                o_bank <= load_idx;
            end
        end
    end

endmodule

// File: tb/tb_x_cmd_des.sv
// Directed bench for x_cmd_des: a 64-bit/2-bank instance and an 8-bit/4-bank
// instance share clock and reset; each scenario task checks its own results.
module tb_x_cmd_des;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        a_valid = 1'b0;
    logic [7:0]  a_cmd   = 8'h00;
    logic        a_accept;
    logic [63:0] a_data;
    logic        a_ovalid;
    logic [0:0]  a_bank;

    logic        b_valid = 1'b0;
    logic [7:0]  b_cmd   = 8'h00;
    logic        b_accept;
    logic [7:0]  b_data;
    logic        b_ovalid;
    logic [1:0]  b_bank;

    int error_count = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    x_cmd_des #(.WIDTH(64), .NUM_BANKS(2)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .o_accept(a_accept),
        .i_cmd(a_cmd), .o_data(a_data), .o_valid(a_ovalid), .o_bank(a_bank)
    );

    x_cmd_des #(.WIDTH(8), .NUM_BANKS(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .o_accept(b_accept),
        .i_cmd(b_cmd), .o_data(b_data), .o_valid(b_ovalid), .o_bank(b_bank)
    );

    // Tasks start and end 1 time unit after a rising edge.
    task automatic issue_a(input logic [7:0] c);
        a_valid = 1'b1;
        a_cmd   = c;
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] c);
        b_valid = 1'b1;
        b_cmd   = c;
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3 rst = 1'b1;
        #1;
        check_count++; if (a_data !== 64'h0) begin error_count++; $display("[TB] FAIL rst_a_data got=%h exp=0", a_data); end
        check_count++; if (a_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL rst_a_valid got=%b exp=0", a_ovalid); end
        check_count++; if (a_bank !== 1'b0) begin error_count++; $display("[TB] FAIL rst_a_bank got=%h exp=0", a_bank); end
        check_count++; if (a_accept !== 1'b1) begin error_count++; $display("[TB] FAIL rst_a_accept got=%b exp=1", a_accept); end
        check_count++; if (b_data !== 8'h0) begin error_count++; $display("[TB] FAIL rst_b_data got=%h exp=0", b_data); end
        check_count++; if (b_accept !== 1'b1) begin error_count++; $display("[TB] FAIL rst_b_accept got=%b exp=1", b_accept); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_count++; if (a_accept !== 1'b1) begin error_count++; $display("[TB] FAIL rst_rel_a_accept got=%b exp=1", a_accept); end
        check_count++; if (a_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL rst_rel_a_valid got=%b exp=0", a_ovalid); end
        check_count++; if (b_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL rst_rel_b_valid got=%b exp=0", b_ovalid); end
    endtask

    task automatic test_shift_apply;
        for (int n = 1; n <= 16; n++) issue_a(8'(n % 16));
        for (int n = 0; n < 16; n++) issue_a(8'h1A);
        issue_a(8'h80);
        check_count++; if (a_data !== 64'h123456789ABCDEF0) begin error_count++; $display("[TB] FAIL sa_bank0_data got=%h exp=123456789abcdef0", a_data); end
        check_count++; if (a_bank !== 1'b0) begin error_count++; $display("[TB] FAIL sa_bank0_idx got=%h exp=0", a_bank); end
        check_count++; if (a_ovalid !== 1'b1) begin error_count++; $display("[TB] FAIL sa_bank0_valid got=%b exp=1", a_ovalid); end
        check_count++; if (a_accept !== 1'b0) begin error_count++; $display("[TB] FAIL sa_accept_low got=%b exp=0", a_accept); end
        @(posedge clk); #1;
        check_count++; if (a_data !== 64'hAAAAAAAAAAAAAAAA) begin error_count++; $display("[TB] FAIL sa_bank1_data got=%h exp=aaaaaaaaaaaaaaaa", a_data); end
        check_count++; if (a_bank !== 1'b1) begin error_count++; $display("[TB] FAIL sa_bank1_idx got=%h exp=1", a_bank); end
        check_count++; if (a_ovalid !== 1'b1) begin error_count++; $display("[TB] FAIL sa_bank1_valid got=%b exp=1", a_ovalid); end
        check_count++; if (a_accept !== 1'b1) begin error_count++; $display("[TB] FAIL sa_accept_back got=%b exp=1", a_accept); end
        @(posedge clk); #1;
        check_count++; if (a_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL sa_valid_drop got=%b exp=0", a_ovalid); end
        check_count++; if (a_data !== 64'hAAAAAAAAAAAAAAAA) begin error_count++; $display("[TB] FAIL sa_data_hold got=%h exp=aaaaaaaaaaaaaaaa", a_data); end
        check_count++; if (a_bank !== 1'b1) begin error_count++; $display("[TB] FAIL sa_bank_hold got=%h exp=1", a_bank); end
    endtask

    task automatic test_overflow;
        for (int n = 0; n < 17; n++) issue_a(8'h0F);
        issue_a(8'h80);
        check_count++; if (a_data !== 64'hFFFFFFFFFFFFFFFF) begin error_count++; $display("[TB] FAIL ovf_bank0 got=%h exp=ffffffffffffffff", a_data); end
        @(posedge clk); #1;
        check_count++; if (a_data !== 64'hAAAAAAAAAAAAAAAA) begin error_count++; $display("[TB] FAIL ovf_bank1_kept got=%h exp=aaaaaaaaaaaaaaaa", a_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_clear_ignore;
        logic [7:0] seq [4];
        seq = '{8'h93, 8'h03, 8'h55, 8'hC7};
        for (int n = 0; n < 4; n++) begin
            check_count++; if (a_accept !== 1'b1) begin error_count++; $display("[TB] FAIL ci_accept_%0d got=%b exp=1", n, a_accept); end
            issue_a(seq[n]);
            check_count++; if (a_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL ci_valid_%0d got=%b exp=0", n, a_ovalid); end
            if (n == 0) begin
                check_count++; if (a_data !== 64'hAAAAAAAAAAAAAAAA) begin error_count++; $display("[TB] FAIL ci_data_unchanged got=%h exp=aaaaaaaaaaaaaaaa", a_data); end
            end
        end
        issue_a(8'h80);
        check_count++; if (a_data !== 64'h3) begin error_count++; $display("[TB] FAIL ci_bank0 got=%h exp=3", a_data); end
        @(posedge clk); #1;
        check_count++; if (a_data !== 64'h0) begin error_count++; $display("[TB] FAIL ci_bank1 got=%h exp=0", a_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [7:0] load [8];
        logic [7:0] exp_data [4];
        load     = '{8'h01, 8'h01, 8'h12, 8'h12, 8'h23, 8'h23, 8'h34, 8'h34};
        exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int n = 0; n < 8; n++) issue_b(load[n]);
        b_valid = 1'b1;
        b_cmd   = 8'h80;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check_count++; if (b_ovalid !== 1'b1) begin error_count++; $display("[TB] FAIL b2b_valid_%0d got=%b exp=1", k, b_ovalid); end
            check_count++; if (b_data !== exp_data[k % 4]) begin error_count++; $display("[TB] FAIL b2b_data_%0d got=%h exp=%h", k, b_data, exp_data[k % 4]); end
            check_count++; if (b_bank !== 2'(k % 4)) begin error_count++; $display("[TB] FAIL b2b_bank_%0d got=%h exp=%0d", k, b_bank, k % 4); end
            check_count++; if (b_accept !== ((k % 4) == 3)) begin error_count++; $display("[TB] FAIL b2b_accept_%0d got=%b exp=%b", k, b_accept, (k % 4) == 3); end
        end
        b_valid = 1'b0;
        @(posedge clk); #1;
        check_count++; if (b_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL b2b_end_valid got=%b exp=0", b_ovalid); end
        check_count++; if (b_data !== 8'h44) begin error_count++; $display("[TB] FAIL b2b_end_hold got=%h exp=44", b_data); end
    endtask

    task automatic test_reset_mid_apply;
        issue_b(8'h80);
        @(posedge clk); #1;
        check_count++; if (b_data !== 8'h22) begin error_count++; $display("[TB] FAIL rma_pre_data got=%h exp=22", b_data); end
        rst = 1'b1;
        #1;
        check_count++; if (b_data !== 8'h00) begin error_count++; $display("[TB] FAIL rma_data got=%h exp=0", b_data); end
        check_count++; if (b_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL rma_valid got=%b exp=0", b_ovalid); end
        check_count++; if (b_bank !== 2'd0) begin error_count++; $display("[TB] FAIL rma_bank got=%h exp=0", b_bank); end
        check_count++; if (b_accept !== 1'b1) begin error_count++; $display("[TB] FAIL rma_accept got=%b exp=1", b_accept); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_count++; if (b_ovalid !== 1'b0) begin error_count++; $display("[TB] FAIL rma_no_valid_%0d got=%b exp=0", k, b_ovalid); end
        end
        issue_b(8'h80);
        for (int k = 0; k < 4; k++) begin
            check_count++; if (b_data !== 8'h00 || b_ovalid !== 1'b1) begin error_count++; $display("[TB] FAIL rma_bank%0d got=%h/%b exp=00/1", k, b_data, b_ovalid); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_shift_apply;
        test_overflow;
        test_clear_ignore;
        test_back_to_back;
        test_reset_mid_apply;
        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
